// File: rtl/prefetch_queue_if.sv
// Instruction-memory request/response bus between prefetch_queue (master) and memory (slave).
interface prefetch_queue_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: circular word buffer feeding one instruction per cycle.
// Define PREFETCH_RVC_EN to support 16-bit compressed instructions and halfword redirects.
module prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    jump,
  input  logic                    fence,
  input  logic [31:0]             npc,
  input  logic                    stall,
  prefetch_queue_if.master        mem,
  output logic                    instr_valid,
  output logic [31:0]             instr,
  output logic [31:0]             pc,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h00000013;

  logic [31:0]   words_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_q, pc_d;
  logic [29:0]   fpc_q, fpc_d;
  logic          redirect, push, consume, pop;
  logic [31:0]   head_w, instr_raw, step;

`ifdef PREFETCH_RVC_EN
  logic          off_q, off_d;
  logic [15:0]   half, next_lo;
  logic          is_comp;
  logic          unused_npc;
  assign unused_npc = npc[0];
`else
  logic [1:0]    unused_npc;
  assign unused_npc = npc[1:0];
`endif

  assign redirect      = jump | fence;
  assign mem.mem_valid = rst & (count_q < CW'(DEPTH));
  assign mem.mem_addr  = {fpc_q, 2'b00};
  assign push          = mem.mem_valid & mem.mem_ready & ~redirect;
  assign head_w        = words_q[head_q];
  assign consume       = instr_valid & ~stall;

  // Decode the instruction at the head of the queue.
  always_comb begin
`ifdef PREFETCH_RVC_EN
    next_lo     = words_q[head_q + AW'(1)][15:0];
    half        = off_q ? head_w[31:16] : head_w[15:0];
    is_comp     = half[1:0] != 2'b11;
    // An upper-half 32-bit instruction spills into the next word.
    instr_valid = (count_q != '0) & (is_comp | ~off_q | (count_q >= CW'(2)));
    instr_raw   = is_comp ? {16'h0000, half} : (off_q ? {next_lo, head_w[31:16]} : head_w);
    pop         = consume & (off_q | ~is_comp);
    step        = is_comp ? 32'd2 : 32'd4;
`else
    instr_valid = count_q != '0;
    instr_raw   = head_w;
    pop         = consume;
    step        = 32'd4;
`endif
    instr = instr_valid ? instr_raw : NOP;
    pc    = pc_q;
    count = count_q;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pc_d    = pc_q;
    fpc_d   = fpc_q;
`ifdef PREFETCH_RVC_EN
    off_d   = off_q;
`endif
    if (redirect) begin
      // Redirect flushes everything, including a response arriving this cycle.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      fpc_d   = npc[31:2];
`ifdef PREFETCH_RVC_EN
      pc_d    = {npc[31:1], 1'b0};
      off_d   = npc[1];
`else
      pc_d    = {npc[31:2], 2'b00};
`endif
    end else begin
      if (push) begin
        tail_d = tail_q + AW'(1);
        fpc_d  = fpc_q + 30'd1;
      end
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      if (consume) begin
        pc_d = pc_q + step;
`ifdef PREFETCH_RVC_EN
        if (is_comp) begin
          off_d = ~off_q;
        end
`endif
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= RESET_PC;
      fpc_q   <= RESET_PC[31:2];
`ifdef PREFETCH_RVC_EN
      off_q   <= RESET_PC[1];
`endif
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      fpc_q   <= fpc_d;
`ifdef PREFETCH_RVC_EN
      off_q   <= off_d;
`endif
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      words_q[tail_q] <= mem.mem_rdata;
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: halfword-stream reference model plus directed scenarios.
module tb_prefetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h00000013;
`ifdef PREFETCH_RVC_EN
  localparam bit          RVC      = 1'b1;
  localparam logic [31:0] JUMP_PC  = 32'h00000102;
`else
  localparam bit          RVC      = 1'b0;
  localparam logic [31:0] JUMP_PC  = 32'h00000100;
`endif

  logic        clk = 1'b0;
  logic        rst, jump, fence, stall;
  logic [31:0] npc;
  logic        instr_valid;
  logic [31:0] instr, pc;
  logic [$clog2(DEPTH):0] count;

  prefetch_queue_if bus ();

  prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .jump       (jump),
    .fence      (fence),
    .npc        (npc),
    .stall      (stall),
    .mem        (bus),
    .instr_valid(instr_valid),
    .instr      (instr),
    .pc         (pc),
    .count      (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the instruction stream as halfwords starting exactly at pc.
  logic [15:0] hq [$];
  logic [31:0] pc_m, fpc_m;
  bit          skip_m;
  logic [31:0] ovr [logic [31:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic model_reset();
    hq.delete();
    pc_m   = RESET_PC;
    fpc_m  = RESET_PC & ~32'h3;
    skip_m = RVC ? RESET_PC[1] : 1'b0;
  endtask

  task automatic cycle(input bit s, input bit r, input bit j, input bit f, input logic [31:0] t);
    int          cnt;
    int          len;
    bit          v;
    logic [31:0] ei, w;
    @(negedge clk);
    stall = s; bus.mem_ready = r; jump = j; fence = f; npc = t;
    bus.mem_rdata = mem_word(bus.mem_addr);
    #2;
    cnt = (hq.size() + int'(pc_m[1])) / 2;
    v = 1'b0; ei = NOP; len = 4;
    if (RVC && hq.size() >= 1 && hq[0][1:0] != 2'b11) begin
      v = 1'b1; ei = {16'h0000, hq[0]}; len = 2;
    end else if (hq.size() >= 2) begin
      v = 1'b1; ei = {hq[1], hq[0]};
    end
    check_eq("mem_valid", 32'(bus.mem_valid), 32'(cnt < DEPTH));
    check_eq("mem_addr", bus.mem_addr, fpc_m);
    check_eq("count", 32'(count), cnt);
    check_eq("instr_valid", 32'(instr_valid), 32'(v));
    check_eq("instr", instr, ei);
    check_eq("pc", pc, pc_m);
    if (j || f) begin
      hq.delete();
      fpc_m = t & ~32'h3;
      if (RVC) begin
        pc_m = t & ~32'h1; skip_m = t[1];
      end else begin
        pc_m = t & ~32'h3; skip_m = 1'b0;
      end
    end else begin
      if (v && !s) begin
        repeat (len / 2) void'(hq.pop_front());
        pc_m += len;
      end
      if (cnt < DEPTH && r) begin
        w = mem_word(fpc_m);
        if (!skip_m) hq.push_back(w[15:0]);
        hq.push_back(w[31:16]);
        skip_m = 1'b0;
        fpc_m += 4;
      end
    end
  endtask

  // Asserts reset at the current time (possibly mid-handshake) and releases it two cycles later.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_eq("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check_eq("rst_mem_addr", bus.mem_addr, RESET_PC & ~32'h3);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", instr, NOP);
    check_eq("rst_pc", pc, RESET_PC);
    stall = 1'b0; jump = 1'b0; fence = 1'b0; npc = '0; bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b1;
  endtask

  logic [31:0] exp_i [3];
  logic [31:0] exp_p [3];

  initial begin
    int  n;
    bit  found;
    rst = 1'b0; jump = 1'b0; fence = 1'b0; stall = 1'b0; npc = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    model_reset();
    for (int a = 0; a < 32; a += 4) ovr[32'(a)] = NOP;

    // Continuous fetch with no stalls.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
      check_eq("stream_addr", bus.mem_addr, 32'(4 * i));
      if (i >= 1) begin
        check_eq("stream_valid", 32'(instr_valid), 32'd1);
        check_eq("stream_pc", pc, 32'(4 * (i - 1)));
      end
    end

    // Stall until full, then drain.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    check_eq("full_count", 32'(count), DEPTH);
    check_eq("full_mem_valid", 32'(bus.mem_valid), 32'd0);
    check_eq("full_pc", pc, 32'h1C);
    check_eq("full_instr", instr, NOP);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Redirect while full.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    check_eq("prejump_count", 32'(count), DEPTH);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h102);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check_eq("jump_count", 32'(count), 32'd0);
    check_eq("jump_mem_addr", bus.mem_addr, 32'h100);
    check_eq("jump_instr_valid", 32'(instr_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
      found = instr_valid;
    end
    check_eq("jump_first_valid", 32'(found), 32'd1);
    check_eq("jump_first_pc", pc, JUMP_PC);

    // Redirect coinciding with an accepted response, via fence.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check_eq("fence_count", 32'(count), 32'd0);
    check_eq("fence_mem_addr", bus.mem_addr, 32'h200);

    // Mixed-width program at address 0.
    ovr.delete();
    ovr[32'h0] = 32'h00134501;
    ovr[32'h4] = 32'h00000013;
`ifdef PREFETCH_RVC_EN
    exp_i[0] = 32'h00004501; exp_i[1] = 32'h00130013; exp_i[2] = 32'h00000000;
    exp_p[0] = 32'h0;        exp_p[1] = 32'h2;        exp_p[2] = 32'h6;
`else
    exp_i[0] = 32'h00134501; exp_i[1] = 32'h00000013; exp_i[2] = mem_word(32'h8);
    exp_p[0] = 32'h0;        exp_p[1] = 32'h4;        exp_p[2] = 32'h8;
`endif
    @(negedge clk);
    do_reset();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
      if (instr_valid && n < 3) begin
        check_eq("prog_instr", instr, exp_i[n]);
        check_eq("prog_pc", pc, exp_p[n]);
        n++;
      end
    end
    check_eq("prog_seen", 32'(n), 32'd3);

    // Randomized traffic with one mid-stream reset.
    ovr.delete();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rv;
      rv = $urandom;
      cycle(rv[1:0] == 2'b00, $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 2, $urandom_range(0, 32'h3FF));
      if (i == 1500) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
